// File: rtl/cavlc_pkg.sv
// rtl/cavlc_pkg.sv - shared state type and coefficient limits for the CAVLC block sequencer
package cavlc_pkg;

  localparam int MAX_COEFF_LUMA      = 16;
  localparam int MAX_COEFF_CHROMA_DC = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TOKEN_0 = 3'd1,
    ST_TOKEN_1 = 3'd2,
    ST_LEVEL   = 3'd3,
    ST_ZERO    = 3'd4
  } cavlc_ctrl_state_t;

endpackage

// File: rtl/cavlc_ctrl_seq_if.sv
// rtl/cavlc_ctrl_seq_if.sv - shifter and sub-decoder signals around the CAVLC block sequencer
interface cavlc_ctrl_seq_if #(
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 16
);
  logic               Enable;
  logic               Abort;
  logic               ChromaDC;
  logic               BarrelShifterReady;
  logic [4:0]         TotalCoeff;
  logic [SHIFT_W-1:0] NumShift_CoeffTokenDecode;
  logic               ShiftEn_LevelDecode;
  logic [SHIFT_W-1:0] NumShift_LevelDecode;
  logic               ShiftEn_ZeroDecode;
  logic [SHIFT_W-1:0] NumShift_ZeroDecode;
  logic               LevelDecodeDone;
  logic               ZeroDecodeDone;
  logic               ShiftEn;
  logic [SHIFT_W-1:0] NumShift;
  logic               CoeffTokenDecodeEnable;
  logic               LevelDecodeEnable;
  logic               ZeroDecodeEnable;
  logic               BlockDone;
  logic               BlockErr;
  logic [CNT_W-1:0]   BlockCount;
  logic               Busy;

  // master is the sequencer; slave is the shifter/sub-decoder side
  modport master (
    input  Enable, Abort, ChromaDC, BarrelShifterReady, TotalCoeff,
           NumShift_CoeffTokenDecode, ShiftEn_LevelDecode, NumShift_LevelDecode,
           ShiftEn_ZeroDecode, NumShift_ZeroDecode, LevelDecodeDone, ZeroDecodeDone,
    output ShiftEn, NumShift, CoeffTokenDecodeEnable, LevelDecodeEnable,
           ZeroDecodeEnable, BlockDone, BlockErr, BlockCount, Busy
  );

  modport slave (
    output Enable, Abort, ChromaDC, BarrelShifterReady, TotalCoeff,
           NumShift_CoeffTokenDecode, ShiftEn_LevelDecode, NumShift_LevelDecode,
           ShiftEn_ZeroDecode, NumShift_ZeroDecode, LevelDecodeDone, ZeroDecodeDone,
    input  ShiftEn, NumShift, CoeffTokenDecodeEnable, LevelDecodeEnable,
           ZeroDecodeEnable, BlockDone, BlockErr, BlockCount, Busy
  );
endinterface

// File: rtl/cavlc_stage_watchdog.sv
// rtl/cavlc_stage_watchdog.sv - per-stage cycle counter; o_timeout marks the last allowed cycle
module cavlc_stage_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_count,
  output logic o_timeout
);
  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  // r_cnt holds the cycles already spent in the stage, so LAST flags the TIMEOUT-th cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_count && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_timeout = (r_cnt == LAST);
endmodule

// File: rtl/cavlc_ctrl_seq.sv
// rtl/cavlc_ctrl_seq.sv - CAVLC residual-block sequencer and barrel-shifter request mux
module cavlc_ctrl_seq
  import cavlc_pkg::*;
#(
  parameter int SHIFT_W      = 5,
  parameter int MAX_COEFF    = MAX_COEFF_LUMA,
  parameter int MAX_COEFF_DC = MAX_COEFF_CHROMA_DC,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 16
) (
  input logic                 Clk,
  input logic                 nReset,
  cavlc_ctrl_seq_if.master    bus
);
  localparam logic [4:0] MAXC_LUMA = 5'(MAX_COEFF);
  localparam logic [4:0] MAXC_DC   = 5'(MAX_COEFF_DC);

  cavlc_ctrl_state_t r_state, w_next;
  logic              r_mode;
  logic [4:0]        r_total;
  logic              r_cte, r_lde, r_zde, r_done, r_err;
  logic [CNT_W-1:0]  r_count;

  logic               w_complete, w_error, w_wd_load, w_wd_count, w_timeout;
  logic               w_shift_en;
  logic [SHIFT_W-1:0] w_num_shift;
  logic [4:0]         w_max_c;

  assign w_max_c = r_mode ? MAXC_DC : MAXC_LUMA;

  cavlc_stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .i_clk     (Clk),
    .i_rst_n   (nReset),
    .i_load    (w_wd_load),
    .i_count   (w_wd_count),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_complete  = 1'b0;
    w_error     = 1'b0;
    w_wd_load   = 1'b0;
    w_wd_count  = 1'b0;
    w_shift_en  = 1'b0;
    w_num_shift = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Enable && bus.BarrelShifterReady) w_next = ST_TOKEN_0;
      end
      ST_TOKEN_0: w_next = ST_TOKEN_1;
      ST_TOKEN_1: begin
        w_num_shift = bus.NumShift_CoeffTokenDecode;
        if (bus.BarrelShifterReady) begin
          w_shift_en = 1'b1;
          if (bus.TotalCoeff > w_max_c) begin
            w_error = 1'b1;
            w_next  = ST_IDLE;
          end else if (bus.TotalCoeff == 5'd0) begin
            w_complete = 1'b1;
          end else begin
            w_next    = ST_LEVEL;
            w_wd_load = 1'b1;
          end
        end
      end
      ST_LEVEL: begin
        w_num_shift = bus.NumShift_LevelDecode;
        w_shift_en  = bus.ShiftEn_LevelDecode & bus.BarrelShifterReady;
        w_wd_count  = 1'b1;
        // a block already holding MaxC coefficients has no zeros left to place
        if (bus.LevelDecodeDone) begin
          if (r_total == w_max_c) begin
            w_complete = 1'b1;
          end else begin
            w_next    = ST_ZERO;
            w_wd_load = 1'b1;
          end
        end else if (w_timeout) begin
          w_error = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      ST_ZERO: begin
        w_num_shift = bus.NumShift_ZeroDecode;
        w_shift_en  = bus.ShiftEn_ZeroDecode & bus.BarrelShifterReady;
        w_wd_count  = 1'b1;
        if (bus.ZeroDecodeDone) begin
          w_complete = 1'b1;
        end else if (w_timeout) begin
          w_error = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_complete) w_next = bus.Enable ? ST_TOKEN_0 : ST_IDLE;
    if (bus.Abort) begin
      w_next     = ST_IDLE;
      w_complete = 1'b0;
      w_error    = 1'b0;
      w_shift_en = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_mode  <= 1'b0;
      r_total <= '0;
      r_cte   <= 1'b0;
      r_lde   <= 1'b0;
      r_zde   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_next == ST_TOKEN_0) r_mode <= bus.ChromaDC;
      if ((r_state == ST_TOKEN_1) && bus.BarrelShifterReady) r_total <= bus.TotalCoeff;
      r_cte  <= (r_state == ST_TOKEN_0);
      r_lde  <= (r_state == ST_LEVEL);
      r_zde  <= (r_state == ST_ZERO);
      r_done <= w_complete;
      r_err  <= w_error;
      if (w_complete && (r_count != {CNT_W{1'b1}})) r_count <= r_count + 1'b1;
    end
  end

  assign bus.ShiftEn                = w_shift_en;
  assign bus.NumShift               = w_num_shift;
  assign bus.CoeffTokenDecodeEnable = r_cte;
  assign bus.LevelDecodeEnable      = r_lde;
  assign bus.ZeroDecodeEnable       = r_zde;
  assign bus.BlockDone              = r_done;
  assign bus.BlockErr               = r_err;
  assign bus.BlockCount             = r_count;
  assign bus.Busy                   = (r_state != ST_IDLE);
endmodule
